// File: rtl/present_inv_key_sched.sv
// present_inv_key_sched: reverse-order PRESENT-80 round-key generator.
// Runs the forward key update 31 times to reach K32, then streams round keys
// K32..K1 over a valid/ready interface by applying the inverse update per key.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, key_in   begin a schedule with the given 80-bit master key (IDLE only)
//   preload         (INV_KSA_PRELOAD_EN only) key_in is already K32; skip FWD
//   busy            high whenever not IDLE
//   rk_valid/ready  round-key stream handshake
//   round_key       K[79:16] of the current key state
//   round_idx       index of round_key, 32 down to 1
//   done            one-cycle pulse after K1 is accepted
//
// Optional feature macro: INV_KSA_PRELOAD_EN
module present_inv_key_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] key_in,
`ifdef INV_KSA_PRELOAD_EN
  input  logic        preload,
`endif
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [63:0] round_key,
  output logic [5:0]  round_idx,
  output logic        done
);

  localparam int unsigned KEY_W      = 80;
  localparam int unsigned RK_W       = 64;
  localparam int unsigned NUM_ROUNDS = 31;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned IDX_W      = 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] REV  = 2'd2;

  logic [1:0]       state, state_d;
  logic [KEY_W-1:0] key, key_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d, busy_d, done_d;

  // PRESENT S-box
  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  // Inverse PRESENT S-box
  function automatic logic [3:0] sinv(input logic [3:0] x);
    case (x)
      4'h0: sinv = 4'h5;  4'h1: sinv = 4'hE;  4'h2: sinv = 4'hF;  4'h3: sinv = 4'h8;
      4'h4: sinv = 4'hC;  4'h5: sinv = 4'h1;  4'h6: sinv = 4'h2;  4'h7: sinv = 4'hD;
      4'h8: sinv = 4'hB;  4'h9: sinv = 4'h4;  4'hA: sinv = 4'h6;  4'hB: sinv = 4'h3;
      4'hC: sinv = 4'h0;  4'hD: sinv = 4'h7;  4'hE: sinv = 4'h9;  default: sinv = 4'hA;
    endcase
  endfunction

  // Forward update: rotl 61, S-box on top nibble, counter into bits 19:15
  function automatic logic [KEY_W-1:0] fwd_upd(input logic [KEY_W-1:0] k,
                                                input logic [CNT_W-1:0] c);
    logic [KEY_W-1:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ c;
    return t;
  endfunction

  // Inverse update: undo counter, inverse S-box, rotr 61 (== rotl 19)
  function automatic logic [KEY_W-1:0] inv_upd(input logic [KEY_W-1:0] k,
                                                input logic [CNT_W-1:0] c);
    logic [KEY_W-1:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ c;
    t[79:76]   = sinv(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    key_d   = key;
    cnt_d   = cnt;
    idx_d   = round_idx;
    valid_d = rk_valid;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          key_d  = key_in;
          busy_d = 1'b1;
`ifdef INV_KSA_PRELOAD_EN
          if (preload) begin
            state_d = REV;
            cnt_d   = CNT_W'(NUM_ROUNDS);
            idx_d   = IDX_W'(NUM_ROUNDS + 1);
            valid_d = 1'b1;
          end else begin
            state_d = FWD;
            cnt_d   = CNT_W'(1);
          end
`else
          state_d = FWD;
          cnt_d   = CNT_W'(1);
`endif
        end
      end
      FWD: begin
        key_d = fwd_upd(key, cnt);
        // Counter parks at 31: it is the first counter REV needs to undo
        if (cnt == CNT_W'(NUM_ROUNDS)) begin
          state_d = REV;
          idx_d   = IDX_W'(NUM_ROUNDS + 1);
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      REV: begin
        if (rk_valid && rk_ready) begin
          if (round_idx == IDX_W'(1)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            key_d = inv_upd(key, cnt);
            cnt_d = cnt - CNT_W'(1);
            idx_d = round_idx - IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key       <= '0;
      cnt       <= '0;
      round_idx <= '0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      key       <= key_d;
      cnt       <= cnt_d;
      round_idx <= idx_d;
      rk_valid  <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  assign round_key = key[KEY_W-1 -: RK_W];

endmodule

// File: tb/tb_present_inv_key_sched.sv
// Testbench for present_inv_key_sched: scoreboard of expected (idx, key)
// pairs built from a forward-schedule model, checked by a negedge monitor.
module tb_present_inv_key_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [79:0] key_in = '0;
  logic        busy, rk_valid, done;
  logic        rk_ready = 1'b1;
  logic [63:0] round_key;
  logic [5:0]  round_idx;
`ifdef INV_KSA_PRELOAD_EN
  logic        preload = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  idx;
    logic [63:0] key;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   ready_rnd = 1'b0;
  bit   stall_prev = 1'b0;
  logic [63:0] stall_key;
  logic [5:0]  stall_idx;

  present_inv_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
`ifdef INV_KSA_PRELOAD_EN
    .preload   (preload),
`endif
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [79:0] m_fwd(input logic [79:0] k, input int r);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = m_sbox(t[79:76]);
    t[19:15] = t[19:15] ^ 5'(r);
    return t;
  endfunction

  function automatic logic [79:0] m_k32(input logic [79:0] k1);
    logic [79:0] k;
    k = k1;
    for (int r = 1; r <= 31; r++) k = m_fwd(k, r);
    return k;
  endfunction

  task automatic push_expected(input logic [79:0] k1);
    logic [79:0] ks [1:32];
    exp_t x;
    ks[1] = k1;
    for (int r = 1; r <= 31; r++) ks[r+1] = m_fwd(ks[r], r);
    for (int i = 32; i >= 1; i--) begin
      x.idx = 6'(i);
      x.key = ks[i][79:16];
      q.push_back(x);
    end
  endtask

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rk_ready driver: always high, or ~30% duty when backpressure is enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rk_ready = ready_rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor: stall stability and scoreboard compare on each handshake
  always @(negedge clk) begin
    if (stall_prev) begin
      n_vec++;
      if (!(rk_valid && round_key == stall_key && round_idx == stall_idx)) begin
        n_err++;
        $display("FAIL stall_hold: got valid=%0b idx=%0d key=%h expected valid=1 idx=%0d key=%h",
                 rk_valid, round_idx, round_key, stall_idx, stall_key);
      end
    end
    stall_prev = rk_valid && !rk_ready && !rst;
    stall_key  = round_key;
    stall_idx  = round_idx;
    if (rk_valid && rk_ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_key: got idx=%0d key=%h expected no key", round_idx, round_key);
      end else begin
        e = q.pop_front();
        if (round_idx !== e.idx || round_key !== e.key) begin
          n_err++;
          $display("FAIL round_key: got idx=%0d key=%h expected idx=%0d key=%h",
                   round_idx, round_key, e.idx, e.key);
        end
      end
    end
  end

  task automatic run_sched(input logic [79:0] key, input logic [79:0] k1, input bit pre,
                           input bit rnd, input bit pulses, input int abort_at);
    int c0, off, first_lat, done_lat;
    bit seen, got;
    first_lat = pre ? 0 : 31;
    done_lat  = pre ? 32 : 63;
    push_expected(k1);
    ready_rnd = rnd;
    @(posedge clk);
    #1;
    start  = 1'b1;
    key_in = key;
`ifdef INV_KSA_PRELOAD_EN
    preload = pre;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    c0    = cyc;
    seen  = 1'b0;
    got   = 1'b0;
    chk("busy_after_start", 80'(busy), 80'(1));
    for (int n = 0; n < 2000; n++) begin
      off = cyc - c0;
      if (!seen && rk_valid) begin
        seen = 1'b1;
        chk("first_valid_latency", 80'(off), 80'(first_lat));
        chk("first_idx", 80'(round_idx), 80'(32));
      end
      if (done) begin
        got = 1'b1;
        if (!rnd) chk("done_latency", 80'(off), 80'(done_lat));
        chk("busy_at_done", 80'(busy), 80'(0));
        break;
      end
      if (abort_at > 0 && off == abort_at - 1) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_valid", 80'(rk_valid), 80'(0));
        chk("abort_busy", 80'(busy), 80'(0));
        chk("abort_idx", 80'(round_idx), 80'(0));
        chk("abort_key", 80'(round_key), 80'(0));
        q.delete();
        ready_rnd = 1'b0;
        return;
      end
      start  = pulses && (off == 10 || off == 40);
      key_in = start ? ~key : key;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    end
    @(posedge clk);
    #1;
    chk("done_pulse_width", 80'(done), 80'(0));
    ready_rnd = 1'b0;
  endtask

  initial begin
    // Reset with a concurrent start request
    rst    = 1'b1;
    start  = 1'b1;
    key_in = {80{1'b1}};
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_busy", 80'(busy), 80'(0));
    chk("reset_valid", 80'(rk_valid), 80'(0));
    chk("reset_done", 80'(done), 80'(0));
    chk("reset_key", 80'(round_key), 80'(0));
    chk("reset_idx", 80'(round_idx), 80'(0));
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("start_during_reset_ignored", 80'(busy), 80'(0));

    // Zero key, with ignored start pulses in FWD and REV
    run_sched(80'h0, 80'h0, 1'b0, 1'b0, 1'b1, 0);
    // All-ones key
    run_sched({80{1'b1}}, {80{1'b1}}, 1'b0, 1'b0, 1'b0, 0);
    // Backpressure
    run_sched(80'h0123456789ABCDEF0123, 80'h0123456789ABCDEF0123, 1'b0, 1'b1, 1'b0, 0);
    // Abort in REV, then a full schedule
    run_sched(80'h0123456789ABCDEF0123, 80'h0123456789ABCDEF0123, 1'b0, 1'b0, 1'b0, 40);
    run_sched(80'h0123456789ABCDEF0123, 80'h0123456789ABCDEF0123, 1'b0, 1'b0, 1'b0, 0);
`ifdef INV_KSA_PRELOAD_EN
    // Preload K32 of the zero key
    run_sched(m_k32(80'h0), 80'h0, 1'b1, 1'b0, 1'b0, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 80'(q.size()), 80'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
